// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, ALU opcodes and mode constants for alu_op_sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GET_B = 2'd1, EXEC = 2'd2, OUT = 2'd3} state_t;
  localparam logic [3:0] OP_ADD     = 4'b1001;
  localparam logic [3:0] OP_SUB_BA  = 4'b0110;
  localparam logic [3:0] OP_AND     = 4'b1011;
  localparam logic [3:0] OP_NOT_B   = 4'b0101;
  localparam logic [3:0] OP_PASS_B0 = 4'b1010;
  localparam logic [3:0] OP_PASS_B1 = 4'b0100;
  localparam logic MODE_ARITH = 1'b1;
  localparam logic MODE_PASS  = 1'b0;
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects A/B words, drives the external ALU, captures its result; ALU_SEQ_CHAIN_EN adds result chaining
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_op,
  input  logic              in_m,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic              in_chain,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_s,
  output logic              alu_m,
  input  logic [DATA_W-1:0] alu_t,
  input  logic              alu_cf,
  input  logic              alu_zf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_t,
  output logic              out_cf,
  output logic              out_zf,
  output logic              busy
);
  state_t state, state_nx;
  logic chain;
`ifdef ALU_SEQ_CHAIN_EN
  assign chain = in_chain;
`else
  assign chain = 1'b0;
`endif
  // next state and handshake outputs; a chained word skips straight to EXEC
  always_comb begin
    in_ready = (state == IDLE) || (state == GET_B);
    busy     = state != IDLE;
    state_nx = state == IDLE  ? (in_valid ? (chain ? EXEC : GET_B) : IDLE) :
               state == GET_B ? (in_valid ? EXEC : GET_B) :
               state == EXEC  ? OUT :
                                (out_ready ? IDLE : OUT);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // operand registers toward the ALU and result capture from it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      alu_m     <= 1'b0;
      out_t     <= '0;
      out_cf    <= 1'b0;
      out_zf    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        alu_s <= in_op;
        alu_m <= in_m;
        alu_a <= chain ? out_t : in_data;
        if (chain) alu_b <= in_data;
      end
      if (state == GET_B && in_valid) alu_b <= in_data;
      if (state == EXEC) begin
        out_t     <= alu_t;
        out_cf    <= alu_cf;
        out_zf    <= alu_zf;
        out_valid <= 1'b1;
      end
      if (state == OUT && out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of alu_op_sequencer against a stub ALU
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_op = '0;
  logic       in_m = 1'b0;
  logic       in_chain = 1'b0;
  logic [7:0] alu_a, alu_b, alu_t, out_t;
  logic [3:0] alu_s;
  logic       alu_m, alu_cf, alu_zf;
  logic       out_valid, out_cf, out_zf, busy;
  logic       out_ready = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] sum;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op), .in_m(in_m),
`ifdef ALU_SEQ_CHAIN_EN
    .in_chain(in_chain),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_t(alu_t), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .out_valid(out_valid), .out_ready(out_ready), .out_t(out_t), .out_cf(out_cf), .out_zf(out_zf),
    .busy(busy)
  );

  // stub ALU: arithmetic ops in MODE_ARITH, passes a through in MODE_PASS
  always_comb begin
    sum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_t  = alu_a;
    alu_cf = 1'b0;
    if (alu_m == MODE_ARITH) begin
      if (alu_s == OP_ADD)                              {alu_cf, alu_t} = sum;
      else if (alu_s == OP_SUB_BA)                      begin alu_t = alu_b - alu_a; alu_cf = alu_b < alu_a; end
      else if (alu_s == OP_AND)                         alu_t = alu_a & alu_b;
      else if (alu_s == OP_NOT_B)                       alu_t = ~alu_b;
      else if (alu_s == OP_PASS_B0 || alu_s == OP_PASS_B1) alu_t = alu_b;
    end
    alu_zf = alu_t == 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_word(input string tag, input logic [7:0] d, input logic [3:0] op, input logic m);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_op = op; in_m = m;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check({tag, "_ready_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [7:0] t, input logic cf, input logic zf);
    check({tag, "_exec_valid"}, out_valid, 0);
    check({tag, "_exec_ready"}, in_ready, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_t"}, out_t, t);
    check({tag, "_cf"}, out_cf, cf);
    check({tag, "_zf"}, out_zf, zf);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_done"}, {out_valid, in_ready, busy}, 3'b010);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic m, input logic [7:0] t, input logic cf, input logic zf);
    send_word(tag, a, op, m);
    send_word(tag, b, 4'h0, 1'b0);
    finish_op(tag, t, cf, zf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_a", alu_a, 0);
    check("rst_t", out_t, 0);
    check("rst_flags", {alu_s, alu_m, out_cf, out_zf, out_valid}, 0);
    check("rst_ready_busy", {in_ready, busy}, 2'b10);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", 8'h80, 8'h80, OP_ADD, MODE_ARITH, 8'h00, 1'b1, 1'b1);
    run_op("sub_neg", 8'h05, 8'h03, OP_SUB_BA, MODE_ARITH, 8'hFE, 1'b1, 1'b0);
    run_op("sub_zero", 8'h03, 8'h03, OP_SUB_BA, MODE_ARITH, 8'h00, 1'b0, 1'b1);
    run_op("pass", 8'h5A, 8'hFF, OP_ADD, MODE_PASS, 8'h5A, 1'b0, 1'b0);
    run_op("not_b", 8'h00, 8'h0F, OP_NOT_B, MODE_ARITH, 8'hF0, 1'b0, 1'b0);

    out_ready = 1'b0;
    send_word("bp", 8'hF0, OP_AND, MODE_ARITH);
    send_word("bp", 8'h3C, 4'h0, 1'b0);
    finish_op("bp", 8'h30, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h07; in_op = OP_ADD; in_m = MODE_ARITH;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, busy, out_t}, {3'b101, 8'h30});
    end
    check("bp_a_kept", alu_a, 8'hF0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", {out_valid, in_ready, busy}, 3'b010);
    check("bp_idle_a", alu_a, 8'hF0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_pending_a", alu_a, 8'h07);
    check("bp_getb", {in_ready, busy}, 2'b11);
    send_word("bp2", 8'h01, 4'h0, 1'b0);
    finish_op("bp2", 8'h08, 1'b0, 1'b0);

    send_word("rst_mid", 8'h11, OP_ADD, MODE_ARITH);
    check("rst_mid_a", alu_a, 8'h11);
    check("rst_mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_regs", {alu_a, alu_b, out_t}, 0);
    check("rst_mid_state", {in_ready, busy, out_valid}, 3'b100);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 8'h01, 8'h02, OP_ADD, MODE_ARITH, 8'h03, 1'b0, 1'b0);

`ifdef ALU_SEQ_CHAIN_EN
    run_op("chain_base", 8'h10, 8'h20, OP_ADD, MODE_ARITH, 8'h30, 1'b0, 1'b0);
    in_chain = 1'b1;
    send_word("chain", 8'h05, OP_ADD, MODE_ARITH);
    in_chain = 1'b0;
    check("chain_ab", {alu_a, alu_b}, 16'h3005);
    finish_op("chain", 8'h35, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream operand/command sequencer for the 8-bit combinational ALU (ports a, b, s, m in; t, cf, zf out). Collects two operand words from a byte-wide valid/ready input stream and registers A, B, opcode and mode onto the ALU inputs. It then samples the ALU result and flags one cycle later and presents them on a valid/ready output channel. The ALU is instantiated beside this block by the parent; this block does not contain it.

Parameters:
DATA_W, 8, operand/result width; must match the ALU (only 8 is supported).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand word valid
in_ready  out  1  sequencer can accept a word
in_data  in  DATA_W  operand word (first = A, second = B)
in_op  in  4  ALU select s, sampled with first word only
in_m  in  1  ALU mode m, sampled with first word only
alu_a  out  DATA_W  registered to ALU a
alu_b  out  DATA_W  registered to ALU b
alu_s  out  4  registered to ALU s
alu_m  out  1  registered to ALU m
alu_t  in  DATA_W  ALU result
alu_cf  in  1  ALU carry/borrow flag
alu_zf  in  1  ALU zero flag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_t  out  DATA_W  captured result
out_cf  out  1  captured carry
out_zf  out  1  captured zero
busy  out  1  high in any state except IDLE

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n.
- Reset: state=IDLE; alu_a, alu_b, out_t=0; alu_s=0; alu_m=0; out_cf, out_zf, out_valid=0. in_ready=1 after reset (IDLE).
- Handshake: a transfer occurs on a rising edge with valid&&ready. Producers must hold data stable while valid is high and ready is low.
- States:
  IDLE: in_ready=1. On transfer: alu_a<=in_data, alu_s<=in_op, alu_m<=in_m; go GET_B.
  GET_B: in_ready=1. On transfer: alu_b<=in_data (in_op/in_m ignored); go EXEC.
  EXEC: in_ready=0. ALU sees settled registered inputs. On the edge ending EXEC: out_t<=alu_t, out_cf<=alu_cf, out_zf<=alu_zf, out_valid<=1; go OUT.
  OUT: in_ready=0, out_valid=1. Outputs are held stable until out_ready=1. On that edge: out_valid<=0; go IDLE.
- Latency: B accepted at edge k gives out_valid=1 after edge k+1. If out_ready is held high, minimum throughput is one op per 4 cycles.
- alu_a/b/s/m hold their last values in IDLE/GET_B until overwritten. Flags are passed through unmodified, with no recomputation.
- in_ready=0 in EXEC/OUT, so there are no overlapping ops. A word presented during OUT waits and is accepted, at the earliest, in the IDLE cycle.
- Reset asserted in any state aborts the op immediately. The partial operand is discarded and out_valid drops asynchronously.
- in_valid with in_ready=0 never changes state.

Optional Feature:
Macro ALU_SEQ_CHAIN_EN.
- Defined: adds input port in_chain (1 bit), sampled with the first word in IDLE. If in_chain=1, the word is taken as B, A is loaded from out_t (the last captured result), op/mode come from in_op/in_m, and the FSM jumps IDLE->EXEC, skipping GET_B.
- Defined, in_chain=1 right after reset: uses A=0.
- Not defined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package alu_seq_pkg:
  - state enum (IDLE, GET_B, EXEC, OUT; 2-bit encoding)
  - opcode constants OP_ADD=4'b1001, OP_SUB_BA=4'b0110 (computes b-a), OP_AND=4'b1011, OP_NOT_B=4'b0101, OP_PASS_B0=4'b1010, OP_PASS_B1=4'b0100
  - MODE_ARITH=1'b1, MODE_PASS=1'b0
- No sub-module; a single FSM plus register file is natural.

Test Plan:
- ADD overflow: m=1, s=1001, A=0x80, B=0x80, out_ready=1 -> out_t=0x00, cf=1, zf=1, out_valid one cycle after B handshake.
- SUB: m=1, s=0110, A=0x05, B=0x03 -> out_t=0xFE, cf=1, zf=0. Then A=0x03, B=0x03 -> out_t=0x00, cf=0, zf=1.
- Back-pressure: AND, A=0xF0, B=0x3C, out_ready low 3 cycles -> out_t=0x30 held stable with out_valid=1 and in_ready=0 throughout; a pending in_valid word is accepted only after return to IDLE.
- Pass mode: m=0, s=1001, A=0x5A, B=0xFF -> out_t=0x5A, cf=0, zf=0.
- Reset mid-op: A=0x11 accepted, rst_n pulsed low in GET_B -> all outputs 0, state IDLE, in_ready=1. A fresh op A=0x01, B=0x02 ADD -> 0x03.
- ALU_SEQ_CHAIN_EN: ADD A=0x10, B=0x20 (out_t=0x30), then chain word 0x05 with ADD -> out_t=0x35 with only one input handshake.
